// File: rtl/modadd432_pipe_pkg.sv
// Shared constants and types for the 432-bit modular adder pipeline.
package modadd_pkg;

    localparam int unsigned MODADD_WIDTH = 432;

    typedef logic [MODADD_WIDTH-1:0] elem_t;
    typedef logic [MODADD_WIDTH:0]   ext_t;

    // Default modulus 2^WIDTH - 1
    localparam elem_t MODADD_MOD = '1;

endpackage

// File: rtl/modadd432_pipe_if.sv
// Operand/result handshake bundle for modadd432_pipe.
// Carries op_sub only when MODADD432_SUB_EN is defined.
interface modadd432_pipe_if #(
    parameter int unsigned WIDTH = modadd_pkg::MODADD_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
`ifdef MODADD432_SUB_EN
    logic             op_sub;

    modport master (
        output in_valid, a_in, b_in, op_sub, out_ready,
        input  in_ready, out_valid, sum_out
    );
    modport slave (
        input  in_valid, a_in, b_in, op_sub, out_ready,
        output in_ready, out_valid, sum_out
    );
`else
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, sum_out
    );
    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, sum_out
    );
`endif
endinterface

// File: rtl/modadd432_pipe_cla.sv
// Combinational carry-lookahead adder, 4-bit lookahead groups with
// group carries chained across the word.
module cla432
    import modadd_pkg::*;
#(
    parameter int unsigned WIDTH = MODADD_WIDTH
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int unsigned NBLK = (WIDTH + 3) / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [NBLK:0]    bc;
    logic [NBLK-1:0]  grp_g;
    logic [NBLK-1:0]  grp_p;

    always_comb begin
        g     = a_in & b_in;
        p     = a_in ^ b_in;
        grp_g = '0;
        grp_p = '1;
        for (int unsigned k = 0; k < NBLK; k++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (4 * k + j < WIDTH) begin
                    grp_g[k] = g[4*k+j] | (p[4*k+j] & grp_g[k]);
                    grp_p[k] = grp_p[k] & p[4*k+j];
                end
            end
        end
    end

    // Group carries only depend on group generate/propagate, not on bit carries
    always_comb begin
        bc    = '0;
        bc[0] = c_in;
        for (int unsigned k = 0; k < NBLK; k++) begin
            bc[k+1] = grp_g[k] | (grp_p[k] & bc[k]);
        end
    end

    always_comb begin
        c = '0;
        for (int unsigned k = 0; k < NBLK; k++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (4 * k + j < WIDTH) begin
                    if (j == 0) begin
                        c[4*k] = bc[k];
                    end
                    c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
                end
            end
        end
    end

    assign sum   = p ^ c[WIDTH-1:0];
    assign c_out = bc[NBLK];

endmodule

// File: rtl/modadd432_pipe.sv
// Two-stage pipelined modular adder: S1 raw CLA sum, S2 conditional reduction.
// MODADD432_SUB_EN adds op_sub for (a - b) mod MOD.
module modadd432_pipe
    import modadd_pkg::*;
#(
    parameter int unsigned    WIDTH = MODADD_WIDTH,
    parameter logic [WIDTH-1:0] MOD = {WIDTH{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    modadd432_pipe_if.slave    bus
);
    logic             adv1;
    logic             adv2;
    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH:0]   s1_ext;
    logic [WIDTH-1:0] s2_sum;
    logic [WIDTH-1:0] cla_b;
    logic             cla_cin;
    logic [WIDTH-1:0] cla_sum;
    logic             cla_cout;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] s2_next;
`ifdef MODADD432_SUB_EN
    logic             s1_sub;
`endif

    always_comb begin
        adv2 = !s2_valid || bus.out_ready;
        adv1 = !s1_valid || adv2;
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid;
    assign bus.sum_out   = s2_sum;

    always_comb begin
        cla_b   = bus.b_in;
        cla_cin = 1'b0;
`ifdef MODADD432_SUB_EN
        if (bus.op_sub) begin
            cla_b   = ~bus.b_in;
            cla_cin = 1'b1;
        end
`endif
    end

    cla432 #(.WIDTH(WIDTH)) u_cla (
        .a_in  (bus.a_in),
        .b_in  (cla_b),
        .c_in  (cla_cin),
        .sum   (cla_sum),
        .c_out (cla_cout)
    );

    // For subtraction the adder carry-out is the inverted borrow of a - b
    always_comb begin
        diff    = s1_ext - {1'b0, MOD};
        s2_next = diff[WIDTH] ? s1_ext[WIDTH-1:0] : diff[WIDTH-1:0];
`ifdef MODADD432_SUB_EN
        if (s1_sub) begin
            s2_next = s1_ext[WIDTH] ? s1_ext[WIDTH-1:0] : s1_ext[WIDTH-1:0] + MOD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_ext   <= '0;
            s2_sum   <= '0;
`ifdef MODADD432_SUB_EN
            s1_sub   <= 1'b0;
`endif
        end else begin
            if (adv1) begin
                s1_valid <= bus.in_valid;
                s1_ext   <= {cla_cout, cla_sum};
`ifdef MODADD432_SUB_EN
                s1_sub   <= bus.op_sub;
`endif
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                s2_sum   <= s2_next;
            end
        end
    end

endmodule

// File: tb/tb_modadd432_pipe.sv
// Directed-vector and scoreboard bench for modadd432_pipe.
module tb_modadd432_pipe;
    import modadd_pkg::*;

    localparam elem_t MOD = MODADD_MOD;
    localparam elem_t H   = {1'b1, 431'b0};

    typedef struct {
        elem_t a;
        elem_t b;
        logic  op;
        elem_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modadd432_pipe_if #(.WIDTH(MODADD_WIDTH)) bus ();

    modadd432_pipe #(.WIDTH(MODADD_WIDTH), .MOD(MOD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    vec_t  vecs[$];
    elem_t qa[$];
    elem_t qb[$];
    logic  qop[$];
    elem_t exp_q[$];

    task automatic check_val(input string name, input elem_t act, input elem_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic elem_t model(input elem_t a, input elem_t b, input logic sub);
        ext_t s;
        if (sub) begin
            s = {1'b0, a} - {1'b0, b};
            if (s[MODADD_WIDTH]) s = s + {1'b0, MOD};
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, MOD}) s = s - {1'b0, MOD};
        end
        return s[MODADD_WIDTH-1:0];
    endfunction

    function automatic elem_t rand_elem();
        logic [447:0] w;
        elem_t e;
        for (int i = 0; i < 14; i++) w[i*32 +: 32] = $urandom();
        e = w[MODADD_WIDTH-1:0];
        case ($urandom_range(7))
            0: e = MOD - elem_t'($urandom_range(8));
            1: e = elem_t'($urandom_range(8));
            default: ;
        endcase
        if (e >= MOD) e = '0;
        return e;
    endfunction

    task automatic drive(input logic v, input elem_t a, input elem_t b, input logic op, input logic rdy);
        bus.in_valid  = v;
        bus.a_in      = a;
        bus.b_in      = b;
        bus.out_ready = rdy;
`ifdef MODADD432_SUB_EN
        bus.op_sub    = op;
`else
        if (op) $display("note: op_sub ignored in add-only build");
`endif
    endtask

    function automatic vec_t mk(input elem_t a, input elem_t b, input logic op, input elem_t exp);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp = exp;
        return v;
    endfunction

    // Streams qa/qb/qop through the DUT, checking outputs against the scoreboard
    task automatic run_stream(input int ready_hold, input int vpct, input int rpct,
                              input int budget, output int acc_at_block, output int n_out);
        int idx;
        int cyc;
        int accepted;
        logic pending;
        logic fire_in;
        logic fire_out;
        logic prev_stall;
        elem_t prev_sum;
        idx = 0; cyc = 0; accepted = 0; pending = 1'b0; prev_stall = 1'b0;
        prev_sum = '0; acc_at_block = -1; n_out = 0;
        while ((idx < qa.size() || exp_q.size() != 0) && cyc < budget) begin
            if (!pending && idx < qa.size() && $urandom_range(99) < vpct) pending = 1'b1;
            drive(pending, pending ? qa[idx] : '0, pending ? qb[idx] : '0,
                  pending ? qop[idx] : 1'b0,
                  (cyc >= ready_hold) && ($urandom_range(99) < rpct));
            #1;
            if (prev_stall) check_val("stall_hold", bus.sum_out, prev_sum);
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (!bus.in_ready && acc_at_block < 0) acc_at_block = accepted;
            if (fire_out) begin
                n_out++;
                if (exp_q.size() == 0) check_bit("spurious_out", fire_out, 1'b0);
                else check_val("stream", bus.sum_out, exp_q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.sum_out;
            @(posedge clk); #1;
            if (fire_in) begin
                exp_q.push_back(model(qa[idx], qb[idx], qop[idx]));
                idx++;
                accepted++;
                pending = 1'b0;
            end
            cyc++;
        end
        check_bit("stream_timeout", cyc >= budget, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        qa.delete(); qb.delete(); qop.delete(); exp_q.delete();
    endtask

    initial begin
        int acc;
        int nout;

        vecs.push_back(mk(elem_t'(5), elem_t'(7), 1'b0, elem_t'(12)));
        vecs.push_back(mk(MOD - 1, elem_t'(1), 1'b0, '0));
        vecs.push_back(mk(MOD - 1, MOD - 1, 1'b0, MOD - 2));
        vecs.push_back(mk(MOD - 5, elem_t'(5), 1'b0, '0));
        vecs.push_back(mk(MOD - 3, elem_t'(2), 1'b0, MOD - 1));
        vecs.push_back(mk(H, H, 1'b0, elem_t'(1)));
        vecs.push_back(mk(H + 3, H - 1, 1'b0, elem_t'(3)));
        vecs.push_back(mk('0, '0, 1'b0, '0));
        vecs.push_back(mk(elem_t'(123456789), elem_t'(987654321), 1'b0, elem_t'(1111111110)));
`ifdef MODADD432_SUB_EN
        vecs.push_back(mk(elem_t'(3), elem_t'(5), 1'b1, MOD - 2));
        vecs.push_back(mk(elem_t'(9), elem_t'(4), 1'b1, elem_t'(5)));
        vecs.push_back(mk('0, MOD - 1, 1'b1, elem_t'(1)));
        vecs.push_back(mk(MOD - 1, '0, 1'b1, MOD - 1));
`endif

        // Reset held with in_valid asserted
        drive(1'b1, elem_t'(5), elem_t'(7), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_bit("rst_out_valid", bus.out_valid, 1'b0);
            check_val("rst_sum_out", bus.sum_out, '0);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_bit("post_rst_idle", bus.out_valid, 1'b0);
        end

        // Directed vectors, one at a time, with exact latency
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            #1;
            check_bit($sformatf("vec%0d_in_ready", i), bus.in_ready, 1'b1);
            @(posedge clk); #1;
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            check_bit($sformatf("vec%0d_lat1", i), bus.out_valid, 1'b0);
            @(posedge clk); #1;
            check_bit($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
            check_val($sformatf("vec%0d_sum", i), bus.sum_out, vecs[i].exp);
            @(posedge clk); #1;
        end

        // Reset while an operand is in flight discards it
        drive(1'b1, elem_t'(5), elem_t'(7), 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_bit("midrst_valid", bus.out_valid, 1'b0);
        check_val("midrst_sum", bus.sum_out, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_bit("midrst_flushed", bus.out_valid, 1'b0);
        end

        // Backpressure: out_ready low for 5 cycles
        for (int i = 1; i <= 4; i++) begin
            qa.push_back(elem_t'(i)); qb.push_back(elem_t'(i)); qop.push_back(1'b0);
        end
        run_stream(5, 100, 100, 200, acc, nout);
        check_int("bp_accepts_before_block", acc, 2);
        check_int("bp_outputs", nout, 4);

`ifdef MODADD432_SUB_EN
        // Mixed add/sub ordering
        for (int i = 0; i < 8; i++) begin
            qa.push_back(elem_t'(10 + i)); qb.push_back(elem_t'(3 * i)); qop.push_back(i[0]);
        end
        run_stream(0, 100, 100, 200, acc, nout);
        check_int("mixed_outputs", nout, 8);
`endif

        // Random stream with random valid/ready
        for (int i = 0; i < 10000; i++) begin
            qa.push_back(rand_elem());
            qb.push_back(rand_elem());
`ifdef MODADD432_SUB_EN
            qop.push_back(1'($urandom_range(1)));
`else
            qop.push_back(1'b0);
`endif
        end
        run_stream(0, 70, 70, 80000, acc, nout);
        check_int("rand_outputs", nout, 10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
